// File: rtl/fwd_pkg.sv
// fwd_pkg: constants and helpers shared by the forwarding selector.
//   SEL_RF    - out_sel code meaning "register file value selected"
//   ZERO_REG  - architectural $0, which never forwards
//   sel_width - width of a source index that covers RF plus n stages
package fwd_pkg;

    localparam int SEL_RF   = 0;
    localparam int ZERO_REG = 0;

    function automatic int sel_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/fwd_sel_reg_prio_match.sv
// prio_match: compares a source-register address against NSRC producer
// stages and picks the lowest-index (youngest) match.
// Ports:
//   rd_addr         in   register address being read
//   src_valid       in   per-stage "writes a register"
//   src_addr        in   per-stage destination address, [i*AW +: AW]
//   src_ready       in   per-stage "result available"
//   hit             out  some stage matches
//   idx             out  index of the winning stage (0 when no hit)
//   ready_of_winner out  src_ready of the winning stage (0 when no hit)
module prio_match
    import fwd_pkg::*;
#(
    parameter int NSRC = 3,
    parameter int AW   = 5
) (
    input  logic [AW-1:0]                rd_addr,
    input  logic [NSRC-1:0]              src_valid,
    input  logic [NSRC*AW-1:0]           src_addr,
    input  logic [NSRC-1:0]              src_ready,
    output logic                         hit,
    output logic [sel_width(NSRC)-1:0]   idx,
    output logic                         ready_of_winner
);

    localparam int SW = sel_width(NSRC);

    logic [NSRC-1:0] match;

    always_comb begin
        match = '0;
        for (int i = 0; i < NSRC; i++) begin
            match[i] = src_valid[i]
                    && (src_addr[i*AW +: AW] == rd_addr)
                    && (rd_addr != AW'(ZERO_REG));
        end
    end

    // Scan from the oldest stage down so the youngest match is written last.
    always_comb begin
        hit             = 1'b0;
        idx             = '0;
        ready_of_winner = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit             = 1'b1;
                idx             = SW'(i);
                ready_of_winner = src_ready[i];
            end
        end
    end

endmodule

// File: rtl/fwd_sel_reg.sv
// fwd_sel_reg: operand forwarding selector plus D/E pipeline register.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   stall, flush    hold / bubble the output register (flush wins)
//   in_valid        upstream instruction is real
//   rd_addr,rf_data source register address and register-file value
//   src_*           per-stage producer valid/addr/ready/data (packed)
//   hazard          combinational load-use flag for the stall logic
//   out_data/valid/sel  registered operand, valid and source index
//   hit_cnt         saturating count of forwarded operands accepted
module fwd_sel_reg
    import fwd_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AW    = 5,
    parameter int NSRC  = 3,
    parameter int CW    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic                        flush,
    input  logic                        in_valid,
    input  logic [AW-1:0]               rd_addr,
    input  logic [WIDTH-1:0]            rf_data,
    input  logic [NSRC-1:0]             src_valid,
    input  logic [NSRC*AW-1:0]          src_addr,
    input  logic [NSRC-1:0]             src_ready,
    input  logic [NSRC*WIDTH-1:0]       src_data,
    output logic                        hazard,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic [sel_width(NSRC)-1:0]  out_sel,
    output logic [CW-1:0]               hit_cnt
);

    localparam int SW = sel_width(NSRC);

    logic          hit;
    logic [SW-1:0] idx;
    logic          win_ready;
    logic [SW-1:0] sel;
    logic [WIDTH-1:0] value;

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    out_sel_q,   out_sel_d;
    logic [CW-1:0]    hit_cnt_q,   hit_cnt_d;

    prio_match #(.NSRC(NSRC), .AW(AW)) u_match (
        .rd_addr         (rd_addr),
        .src_valid       (src_valid),
        .src_addr        (src_addr),
        .src_ready       (src_ready),
        .hit             (hit),
        .idx             (idx),
        .ready_of_winner (win_ready)
    );

    always_comb begin
        sel   = hit ? (idx + SW'(1)) : SW'(SEL_RF);
        value = rf_data;
        for (int i = 0; i < NSRC; i++) begin
            if (hit && (idx == SW'(i))) begin
                value = src_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Only the winning stage's readiness matters; an older ready copy of the
    // same register is stale relative to the younger pending write.
    assign hazard = in_valid && hit && !win_ready;

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        hit_cnt_d   = hit_cnt_q;
        if (flush) begin
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_sel_d   = SW'(SEL_RF);
        end else if (stall) begin
            // hold
        end else if (hazard) begin
            // Bubble even if the controller failed to stall.
            out_data_d  = '0;
            out_valid_d = 1'b0;
            out_sel_d   = SW'(SEL_RF);
        end else begin
            out_data_d  = value;
            out_valid_d = in_valid;
            out_sel_d   = sel;
            if (in_valid && (sel != SW'(SEL_RF)) && (hit_cnt_q != {CW{1'b1}})) begin
                hit_cnt_d = hit_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            hit_cnt_q   <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            hit_cnt_q   <= hit_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_sel   = out_sel_q;
    assign hit_cnt   = hit_cnt_q;

endmodule

// File: doc/fwd_sel_reg.md
# fwd_sel_reg

Parametrised forwarding selector plus pipeline register for the P5-class pipelined MIPS core, generalising the fixed 2/4-way select muxes. Each cycle it compares a source-register address against NSRC in-flight producer stages, picks the nearest valid producer (or the register-file value), and flags a load-use hazard when that producer's data is not yet available. It registers the result into the next stage with stall and flush control. One instance sits per operand (rs, rt) at the D/E boundary.

## Interface
Parameters:
- WIDTH, 32, data width
- AW, 5, register-address width
- NSRC, 3, number of forwarding sources; index 0 is the nearest (youngest) stage
- CW, 16, width of the forwarded-hit counter

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold the output register
- flush  in  1  insert a bubble into the output register
- in_valid  in  1  the upstream instruction is real
- rd_addr  in  AW  source register address being read
- rf_data  in  WIDTH  register-file read value
- src_valid  in  NSRC  producer stage i writes a register
- src_addr  in  NSRC*AW  destination address of stage i, packed as [i*AW +: AW]
- src_ready  in  NSRC  stage i's result is available this cycle
- src_data  in  NSRC*WIDTH  result of stage i, packed as [i*WIDTH +: WIDTH]
- hazard  out  1  combinational; the selected producer is not ready
- out_data  out  WIDTH  registered operand
- out_valid  out  1  registered valid
- out_sel  out  $clog2(NSRC+1)  registered source index; 0 = register file, i+1 = stage i
- hit_cnt  out  CW  count of forwarded (non-RF) operands accepted; saturating

## Operation
- match[i] = src_valid[i] && src_addr[i] == rd_addr && rd_addr != 0. Register $0 never forwards.
- Selection uses strict priority: the lowest matching i wins. If nothing matches, rf_data is selected with sel = 0.
- hazard = in_valid && some stage matches && !src_ready[winner]. An older ready stage never overrides a younger not-ready one.
- Register update priority is reset > flush > stall > load.
  - reset: out_data = 0, out_valid = 0, out_sel = 0, hit_cnt = 0.
  - flush: out_data = 0, out_valid = 0, out_sel = 0. hit_cnt is unchanged.
  - stall: all registers hold.
  - load with hazard = 1: bubble (out_valid = 0, out_data = 0, out_sel = 0). The block self-protects if the controller fails to stall.
  - load otherwise: out_data = selected value, out_valid = in_valid, out_sel = sel.
- hit_cnt increments by 1 on a load with out_valid becoming 1 and sel != 0. It saturates at 2^CW-1 and never wraps.

## Timing
- hazard, together with the internal sel and value, is purely combinational from the inputs in the same cycle. It is intended to drive the core's stall logic.
- out_* registers have one-cycle latency: inputs sampled at edge k appear after edge k.
- After reset deasserts, all outputs are 0 until the first load.
- flush and stall asserted together: flush wins.
- reset asserted mid-stall: all outputs clear on that edge.
- A ready stage and a not-ready stage both matching: the younger (lower index) decides. If it is not ready, hazard = 1.
- NSRC = 1 must be legal. out_sel width is then 1.

## Structure
- Package fwd_pkg holds:
  - SEL_RF = 0
  - ZERO_REG = 0
  - function sel_width(n) returning $clog2(n+1)
- Sub-module prio_match (parameters NSRC, AW): a combinational match vector plus a lowest-index priority encoder producing hit, idx, and ready_of_winner.
- The top level holds the data mux, the hazard gate, the pipeline registers, and the saturating counter.

## Test plan
- Reset: reset = 1 for 2 cycles, then released -> out_data = 0, out_valid = 0, out_sel = 0, hit_cnt = 0.
- No match and $0 rule:
  - rd_addr = 5, no src_valid, rf_data = 0x1111 -> next cycle out_data = 0x1111, out_sel = 0.
  - rd_addr = 0 with stage 0 addr = 0 and valid -> RF selected.
- Priority: stages 0 and 2 both match addr 8 and are ready, data 0xA0 and 0xC2 -> out_data = 0xA0, out_sel = 1, hit_cnt = 1.
- Load-use:
  - Stage 0 matches with src_ready = 0 and stage 1 matches and is ready -> hazard = 1 in the same cycle.
  - With stall = 0 -> out_valid = 0 next cycle.
  - With stall = 1 -> outputs hold.
- Control precedence:
  - stall = 1 and flush = 1 together -> bubble.
  - stall = 1 alone for 3 cycles -> out_data is constant while inputs change.
- Saturation: with CW = 4, 20 consecutive forwarded loads -> hit_cnt = 15 and stays at 15.
